vram_port_arbiter: RTL

- Owns port A of the 16 KB dual-port video RAM and shares it between two requesters:
  - the CPU/ISA bus-side video memory interface (single byte reads and writes, req/ack handshake);
  - a hardware fill engine that clears or fills a region with a constant byte (screen clear, mode-switch blanking).
- Port B stays dedicated to the CRTC/pixel fetch and is outside this block.
- The CPU has fixed priority; the fill engine uses every port cycle the CPU leaves free.

---
 rtl/vram_port_arbiter_if.sv | 46 ++++
 rtl/vram_port_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/vram_port_arbiter_if.sv
// Bundle of the CPU, fill-engine and RAM port A signals around the VRAM port arbiter.
// The slave modport is the arbiter's view; the master modport is the view of the
// requesters and the RAM that surround it.
`timescale 1ns/1ps
interface vram_port_arbiter_if #(
    parameter int AW = 14,
    parameter int DW = 8
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;

    logic          fill_start;
    logic [AW-1:0] fill_base;
    logic [AW:0]   fill_len;
    logic [DW-1:0] fill_data;
    logic          fill_busy;
    logic          fill_done;

    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  fill_start, fill_base, fill_len, fill_data,
        output fill_busy, fill_done,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output fill_start, fill_base, fill_len, fill_data,
        input  fill_busy, fill_done,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/vram_port_arbiter.sv
// VRAM port A arbiter: CPU byte accesses have fixed priority, the fill engine
// writes a constant byte in every port cycle the CPU leaves free.
//
// CPU FSM
//   state    | meaning
//   C_IDLE   | waiting for cpu_req
//   C_STROBE | CPU owns the port this cycle (write acks here)
//   C_RDWAIT | RAM output register holds read data; latched at end of cycle
//   C_ACK    | read ack cycle, cpu_req ignored
//
// Fill FSM
//   state  | meaning
//   F_IDLE | waiting for fill_start
//   F_RUN  | writes pending (rem != 0) or last write on the port (rem == 0)
//   F_DONE | fill_done pulse; a new fill_start is accepted here
`timescale 1ns/1ps
module vram_port_arbiter #(
    parameter int AW = 14,
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    vram_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {C_IDLE, C_STROBE, C_RDWAIT, C_ACK} cpu_state_t;
    typedef enum logic [1:0] {F_IDLE, F_RUN, F_DONE}             fill_state_t;

    cpu_state_t    r_cpu_state;
    logic          r_cpu_rd;
    logic          r_cpu_ack;
    logic [DW-1:0] r_cpu_rdata;

    fill_state_t   r_fill_state;
    logic [AW-1:0] r_fill_addr;
    logic [AW:0]   r_fill_rem;
    logic [DW-1:0] r_fill_data;
    logic          r_fill_busy;
    logic          r_fill_done;

    logic          r_ram_en;
    logic          r_ram_we;
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_wdata;

    logic          w_cpu_take;
    logic          w_fill_accept;
    logic          w_fill_wr;
    logic [AW-1:0] w_fill_wr_addr;
    logic [DW-1:0] w_fill_wr_data;

    // The CPU claims the next port cycle whenever it requests from idle.
    assign w_cpu_take    = (r_cpu_state == C_IDLE) && bus.cpu_req;

    // A start is taken in idle and in the done cycle, never while running.
    assign w_fill_accept = bus.fill_start && (r_fill_state != F_RUN);

    // The first fill write is issued straight from the start inputs so the
    // writes line up with fill_busy; the CPU still wins a contended edge.
    assign w_fill_wr = !w_cpu_take &&
                       ((w_fill_accept && (bus.fill_len != '0)) ||
                        ((r_fill_state == F_RUN) && (r_fill_rem != '0)));

    assign w_fill_wr_addr = w_fill_accept ? bus.fill_base : r_fill_addr;
    assign w_fill_wr_data = w_fill_accept ? bus.fill_data : r_fill_data;

    // CPU access sequencing: strobe, optional read wait, ack with read data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cpu_state <= C_IDLE;
            r_cpu_rd    <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_cpu_rdata <= '0;
        end else begin
            r_cpu_ack <= 1'b0;
            case (r_cpu_state)
                C_IDLE: begin
                    if (bus.cpu_req) begin
                        r_cpu_state <= C_STROBE;
                        r_cpu_rd    <= !bus.cpu_we;
                        r_cpu_ack   <= bus.cpu_we;
                    end
                end
                C_STROBE: begin
                    r_cpu_state <= r_cpu_rd ? C_RDWAIT : C_IDLE;
                end
                C_RDWAIT: begin
                    r_cpu_rdata <= bus.ram_rdata;
                    r_cpu_ack   <= 1'b1;
                    r_cpu_state <= C_ACK;
                end
                C_ACK: begin
                    r_cpu_state <= C_IDLE;
                end
                default: begin
                    r_cpu_state <= C_IDLE;
                end
            endcase
        end
    end

    // Fill engine: address/count bookkeeping plus busy/done flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fill_state <= F_IDLE;
            r_fill_addr  <= '0;
            r_fill_rem   <= '0;
            r_fill_data  <= '0;
            r_fill_busy  <= 1'b0;
            r_fill_done  <= 1'b0;
        end else begin
            r_fill_done <= 1'b0;
            case (r_fill_state)
                F_IDLE, F_DONE: begin
                    r_fill_state <= F_IDLE;
                    r_fill_busy  <= 1'b0;
                    if (bus.fill_start) begin
                        r_fill_data <= bus.fill_data;
                        if (bus.fill_len == '0) begin
                            r_fill_state <= F_DONE;
                            r_fill_done  <= 1'b1;
                        end else begin
                            r_fill_state <= F_RUN;
                            r_fill_busy  <= 1'b1;
                            r_fill_addr  <= w_fill_wr ? bus.fill_base + AW'(1) : bus.fill_base;
                            r_fill_rem   <= w_fill_wr ? bus.fill_len - (AW+1)'(1) : bus.fill_len;
                        end
                    end
                end
                F_RUN: begin
                    if (r_fill_rem == '0) begin
                        r_fill_state <= F_DONE;
                        r_fill_busy  <= 1'b0;
                        r_fill_done  <= 1'b1;
                    end else if (w_fill_wr) begin
                        r_fill_addr <= r_fill_addr + AW'(1);
                        r_fill_rem  <= r_fill_rem - (AW+1)'(1);
                    end
                end
                default: begin
                    r_fill_state <= F_IDLE;
                    r_fill_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Registered port A strobe: CPU first, otherwise a fill write, otherwise idle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else if (w_cpu_take) begin
            r_ram_en    <= 1'b1;
            r_ram_we    <= bus.cpu_we;
            r_ram_addr  <= bus.cpu_addr;
            r_ram_wdata <= bus.cpu_wdata;
        end else if (w_fill_wr) begin
            r_ram_en    <= 1'b1;
            r_ram_we    <= 1'b1;
            r_ram_addr  <= w_fill_wr_addr;
            r_ram_wdata <= w_fill_wr_data;
        end else begin
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
        end
    end

    assign bus.cpu_ack   = r_cpu_ack;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.fill_busy = r_fill_busy;
    assign bus.fill_done = r_fill_done;
    assign bus.ram_en    = r_ram_en;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_wdata = r_ram_wdata;

endmodule
